// File: rtl/mem_stage.sv
// mem_stage: Beta MEM stage; registers execute outputs and runs LD/LDR/ST on a req/ack bus.
// Latency: 1 cycle register stage plus memory wait cycles; outputs are combinational from stage regs and bus.
// Backpressure: stalls upstream and emits NOP bubbles while waiting on ack; abandons access after ACK_TIMEOUT cycles.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc, ir, y, d        pipeline inputs from execute (y is effective address, d is store data)
//   stall               hold IF/RF/ALU pipeline registers this cycle
//   dmem_*              data memory request/ack bus
//   pc_next, ir_next, y_next  values forwarded to write-back
//   mem_fault           one-cycle pulse when an access is abandoned
module mem_stage #(
  parameter int          ACK_TIMEOUT = 16,
  parameter logic [31:0] NOP_INST    = 32'h83FFF800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic [31:0] y,
  input  logic [31:0] d,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] pc_next,
  output logic [31:0] ir_next,
  output logic [31:0] y_next,
  output logic        mem_fault
);

  localparam int CW = $clog2(ACK_TIMEOUT) + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]   r_pc, r_ir, r_y, r_d;

  logic [5:0]    w_opc;
  logic          w_ld, w_st, w_ldr, w_mem_op;
  logic          w_timeout, w_ack;

  assign w_opc    = r_ir[31:26];
  assign w_ld     = (w_opc == 6'b011000);
  assign w_st     = (w_opc == 6'b011001);
  assign w_ldr    = (w_opc == 6'b011111);
  assign w_mem_op = w_ld | w_st | w_ldr;

  // Final wait cycle: the request is withdrawn, so any ack seen here has no
  // request to complete and is ignored.
  assign w_timeout = (r_state == S_WAIT) && (r_cnt == CW'(ACK_TIMEOUT - 1));

  assign dmem_req   = w_mem_op && !w_timeout && !rst;
  assign w_ack      = dmem_req && dmem_ack;
  assign dmem_we    = w_st;
  assign dmem_addr  = {r_y[31:2], 2'b00};
  assign dmem_wdata = r_d;
  assign pc_next    = r_pc;

  always_comb begin
    stall       = 1'b0;
    ir_next     = r_ir;
    y_next      = r_y;
    mem_fault   = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    // During reset the bus is idle and nothing may stall; the register
    // process restores IDLE on the edge.
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            if (w_ack) begin
              if (w_ld || w_ldr) y_next = dmem_rdata;
            end else begin
              stall       = 1'b1;
              ir_next     = NOP_INST;
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = CW'(1);
            end
          end
        end
        S_WAIT: begin
          if (w_timeout) begin
            mem_fault   = 1'b1;
            ir_next     = NOP_INST;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_ack) begin
            if (w_ld || w_ldr) y_next = dmem_rdata;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            stall     = 1'b1;
            ir_next   = NOP_INST;
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_ir    <= NOP_INST;
      r_y     <= '0;
      r_d     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (!stall) begin
        r_pc <= pc;
        r_ir <= ir;
        r_y  <= y;
        r_d  <= d;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Fourth stage of the Beta pipeline (IF, RF, ALU, MEM, WB). It sits directly downstream of the ALU/execute stage and upstream of write-back.
- It registers the pc, ir, ALU result y and store data d produced by execute. It performs LD, LDR and ST accesses on a req/ack data-memory bus and forwards pc, ir and result to write-back.
- Memory latency is variable, so the stage stalls the upstream pipeline and inserts bubbles into write-back. A bounded timeout prevents a lost ack from hanging the CPU.

Parameters:
- ACK_TIMEOUT, 16: maximum number of cycles a request stays outstanding without ack before it is abandoned. Legal range is 2 and up.
- NOP_INST, 32'h83FFF800: bubble instruction, ADD(R31,R31,R31). It is equal to `INST_NOP.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- pc  in  32  pc from execute (pc_next of execute)
- ir  in  32  instruction from execute (ir_next of execute)
- y  in  32  ALU result from execute; this is the effective address for memory ops
- d  in  32  store data (Rc value) from execute
- stall  out  1  when high, IF/RF/ALU stages hold their pipeline registers this cycle
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = write (ST), 0 = read
- dmem_addr  out  32  {y_mem[31:2],2'b00}; word aligned
- dmem_wdata  out  32  d_mem
- dmem_rdata  in  32  read data, valid when dmem_ack=1
- dmem_ack  in  1  access complete this cycle
- pc_next  out  32  pc to write-back
- ir_next  out  32  instruction to write-back
- y_next  out  32  result to write-back
- mem_fault  out  1  one-cycle pulse when an access times out

Behaviour:
- Pipeline registers pc_mem, ir_mem, y_mem and d_mem load pc, ir, y and d on every rising edge where stall=0. They hold while stall=1.
- Reset values: ir_mem=NOP_INST; pc_mem, y_mem and d_mem = 0; state=IDLE; counter=0.
- Decode uses ir_mem[31:26]:
  - ld: 011000
  - st: 011001
  - ldr: 011111
  - mem_op = ld|st|ldr; all other opcodes are non-memory.
- dmem_req = mem_op while state is IDLE or WAIT. It is forced to 0 in the timeout cycle and in any cycle where rst=1.
- dmem_we = st. dmem_addr and dmem_wdata come from registers, so they are stable for the whole request.
- dmem_ack is ignored when dmem_req=0.
- FSM:
  - IDLE, mem_op=0: stall=0. Outputs pass through: ir_next=ir_mem, y_next=y_mem.
  - IDLE, mem_op=1, ack=1 (zero-wait access): stall=0; state stays IDLE.
  - IDLE, mem_op=1, ack=0: stall=1, ir_next=NOP_INST; next state WAIT; counter<=1.
  - WAIT, ack=1: stall=0, ir_next=ir_mem; next state IDLE; counter<=0.
  - WAIT, ack=0, counter<ACK_TIMEOUT-1: stall=1, ir_next=NOP_INST; counter<=counter+1.
  - WAIT, ack=0, counter==ACK_TIMEOUT-1 (timeout cycle): dmem_req=0, stall=0, ir_next=NOP_INST (the instruction is dropped), mem_fault=1; next state IDLE; counter<=0.
- Completion cycle (ack=1 with stall=0):
  - ld/ldr: y_next=dmem_rdata.
  - st: y_next=y_mem. ST has no Rc writeback, so write-back ignores y_next.
- pc_next=pc_mem in every cycle.
- All outputs except registered state are combinational from the stage registers and the bus. Write-back registers them.
- Back-to-back memory ops: after completion, the next instruction loads at the same edge and may assert req in the very next cycle. There is no idle gap.
- mem_fault is high only in the timeout cycle. An ack arriving after a timeout is ignored unless a new request is active.
- Reset mid-access:
  - In the rst cycle, req=0 and stall=0.
  - On the next cycle the state is IDLE and ir_mem=NOP_INST.
  - The abandoned access is not retried.
- Counter width is $clog2(ACK_TIMEOUT)+1 bits. It never wraps because it resets on ack or timeout.

Test Plan:
- Reset, then ADD passes through: ir=ADD, y=32'h5 → next cycle ir_next=ADD, y_next=5, stall=0, dmem_req=0.
- LD, zero-wait: y=32'h0000_0103, ack=1 with rdata=32'hDEADBEEF in the same cycle → dmem_addr=32'h100, dmem_we=0, y_next=32'hDEADBEEF, stall never 1.
- ST, 3-cycle latency: y=32'h200, d=32'h1234, ack on the 3rd req cycle → stall=1 and ir_next=NOP for 2 cycles; wdata=32'h1234 and we=1 stable throughout; upstream pc held; ST reaches ir_next in cycle 3.
- Back-to-back LDR then LD, each acked after 1 wait cycle → two NOP bubbles total; req re-asserts the cycle after the first completion with the new address.
- Timeout with ACK_TIMEOUT=4, ack never asserted → req high for cycles 0–2, low in cycle 3 with mem_fault=1, ir_next=NOP, stall=0; a late ack in cycle 4 is ignored.
- rst asserted in the 2nd wait cycle of an LD → same cycle req=0; next cycle state IDLE, ir_next=NOP_INST, no fault pulse.
